// File: rtl/checked_add_seq_if.sv
// Handshake bundle for checked_add_seq: operand side (in_*) and result side (out_*).
// master drives operands and out_ready; slave is the adder block.
interface checked_add_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             inj;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ok;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in0, in1, sel, inj, out_ready,
    input  in_ready, out_valid, sum, carry, ok, err_cnt
  );

  modport slave (
    input  in_valid, in0, in1, sel, inj, out_ready,
    output in_ready, out_valid, sum, carry, ok, err_cnt
  );
endinterface

// File: rtl/checked_add_seq.sv
// Self-checking unsigned adder: a one-shot arithmetic add cross-checked by a 2-bit-per-cycle LUT ripple.
// Optional build macro CHECKED_ADD_FAULT_INJ_EN enables corrupting the LUT path via a latched inj.
module checked_add_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  checked_add_seq_if.slave bus
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef CHECKED_ADD_FAULT_INJ_EN
  localparam bit FAULT_INJ = 1'b1;
`else
  localparam bit FAULT_INJ = 1'b0;
`endif

  function automatic logic [2:0] rom_entry(input logic [4:0] addr);
    return {1'b0, addr[4:3]} + {1'b0, addr[2:1]} + {2'b0, addr[0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             sel_lat;
  logic             inj_lat;
  logic [WIDTH:0]   arith_res;
  logic [WIDTH-1:0] lut_sum;
  logic             lut_c;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ok_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic [2:0]       rom [32];
  logic [1:0]       a_chunk;
  logic [1:0]       b_chunk;
  logic             cin;
  logic [2:0]       lut_out;
  logic [1:0]       s_chunk;
  logic [WIDTH-1:0] lut_sum_nxt;
  logic             last;
  logic             ok_nxt;

  always_comb begin
    for (int i = 0; i < 32; i++) rom[i] = rom_entry(5'(i));
  end

  // LUT path: one 2-bit chunk per RUN cycle, rippling the chunk carry.
  always_comb begin
    a_chunk     = a_lat[{idx, 1'b0} +: 2];
    b_chunk     = b_lat[{idx, 1'b0} +: 2];
    cin         = (idx == '0) ? 1'b0 : lut_c;
    lut_out     = rom[{a_chunk, b_chunk, cin}];
    // injected fault flips only the sum bit; chunk 0 carry is left intact
    s_chunk     = lut_out[1:0] ^ {1'b0, FAULT_INJ & inj_lat & (idx == '0)};
    lut_sum_nxt = lut_sum;
    lut_sum_nxt[{idx, 1'b0} +: 2] = s_chunk;
    last        = (idx == IDX_W'(N - 1));
    ok_nxt      = ({lut_out[2], lut_sum_nxt} == arith_res);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_lat     <= '0;
      b_lat     <= '0;
      sel_lat   <= 1'b0;
      inj_lat   <= 1'b0;
      arith_res <= '0;
      lut_sum   <= '0;
      lut_c     <= 1'b0;
      idx       <= '0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      ok_r      <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_lat     <= bus.in0;
            b_lat     <= bus.in1;
            sel_lat   <= bus.sel;
            inj_lat   <= bus.inj;
            arith_res <= {1'b0, bus.in0} + {1'b0, bus.in1};
            lut_sum   <= '0;
            lut_c     <= 1'b0;
            idx       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          lut_sum <= lut_sum_nxt;
          lut_c   <= lut_out[2];
          if (last) begin
            sum_r   <= sel_lat ? lut_sum_nxt : arith_res[WIDTH-1:0];
            carry_r <= sel_lat ? lut_out[2]  : arith_res[WIDTH];
            ok_r    <= ok_nxt;
            if (!ok_nxt) err_cnt_r <= sat_inc(err_cnt_r);
            state   <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.ok        = ok_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_checked_add_seq.sv
// Directed bench for checked_add_seq: WIDTH=8 main instance, a CNT_W=2 twin sharing its stimulus,
// and a WIDTH=2 instance.
module tb_checked_add_seq;

`ifdef CHECKED_ADD_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  checked_add_seq_if #(.WIDTH(8), .CNT_W(8)) b8 ();
  checked_add_seq_if #(.WIDTH(8), .CNT_W(2)) bc ();
  checked_add_seq_if #(.WIDTH(2), .CNT_W(8)) b2 ();

  checked_add_seq #(.WIDTH(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  checked_add_seq #(.WIDTH(8), .CNT_W(2)) u_dutc (.clk(clk), .rst(rst), .bus(bc.slave));
  checked_add_seq #(.WIDTH(2), .CNT_W(8)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  assign bc.in_valid  = b8.in_valid;
  assign bc.in0       = b8.in0;
  assign bc.in1       = b8.in1;
  assign bc.sel       = b8.sel;
  assign bc.inj       = b8.inj;
  assign bc.out_ready = b8.out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic s, input logic j);
    int g = 0;
    while (!b8.in_ready && g < 20) begin
      tick();
      g++;
    end
    check("accept_rdy", b8.in_ready, 1);
    b8.in0 = a; b8.in1 = b; b8.sel = s; b8.inj = j;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat);
    int c = 0;
    while (!b8.out_valid && c < 20) begin
      tick();
      c++;
    end
    check(tag, c, lat);
  endtask

  task automatic result(input string tag, input logic [7:0] es, input logic ec, input logic eo,
                        input logic [7:0] ee, input logic [1:0] ecc);
    check({tag, "_sum"}, b8.sum, es);
    check({tag, "_carry"}, b8.carry, ec);
    check({tag, "_ok"}, b8.ok, eo);
    check({tag, "_err"}, b8.err_cnt, ee);
    check({tag, "_errc2"}, bc.err_cnt, ecc);
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    check({tag, "_idle_rdy"}, b8.in_ready, 1);
    check({tag, "_idle_vld"}, b8.out_valid, 0);
  endtask

  initial begin
    int seen;
    int c;
    logic [7:0] es;
    logic [1:0] ecc;
    rst = 1'b1;
    b8.in_valid = 0; b8.in0 = 0; b8.in1 = 0; b8.sel = 0; b8.inj = 0; b8.out_ready = 0;
    b2.in_valid = 0; b2.in0 = 0; b2.in1 = 0; b2.sel = 0; b2.inj = 0; b2.out_ready = 0;
    tick();
    tick();
    check("rst_rdy", b8.in_ready, 1);
    check("rst_vld", b8.out_valid, 0);
    check("rst_sum", b8.sum, 0);
    check("rst_carry", b8.carry, 0);
    check("rst_ok", b8.ok, 0);
    check("rst_err", b8.err_cnt, 0);
    rst = 1'b0;
    tick();

    // carry out of the top chunk
    accept(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_out("s1_lat", 4);
    result("s1", 8'h00, 1'b1, 1'b1, 8'd0, 2'd0);

    // LUT path with back-pressure; in_valid held high while busy must be ignored
    accept(8'hA5, 8'h3C, 1'b1, 1'b0);
    b8.in0 = 8'h00; b8.in1 = 8'h00; b8.sel = 1'b0; b8.inj = 1'b0; b8.in_valid = 1'b1;
    wait_out("s2_lat", 4);
    for (int i = 0; i < 3; i++) begin
      check("s2_hold_vld", b8.out_valid, 1);
      check("s2_hold_sum", b8.sum, 8'hE1);
      check("s2_hold_rdy", b8.in_ready, 0);
      tick();
    end
    check("s2_sum", b8.sum, 8'hE1);
    check("s2_carry", b8.carry, 0);
    check("s2_ok", b8.ok, 1);
    check("s2_err", b8.err_cnt, 0);
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    check("s2_noacc_rdy", b8.in_ready, 1);
    check("s2_noacc_vld", b8.out_valid, 0);
    tick();
    b8.in_valid = 1'b0;
    check("s2_acc_next", b8.in_ready, 0);
    wait_out("s2b_lat", 4);
    result("s2b", 8'h00, 1'b0, 1'b1, 8'd0, 2'd0);

    // fault injection: 12+34=46 arithmetically, LUT gives 47 when enabled
    accept(8'h12, 8'h34, 1'b0, 1'b1);
    wait_out("s3_lat", 4);
    result("s3", 8'h46, 1'b0, !FI, FI ? 8'd1 : 8'd0, FI ? 2'd1 : 2'd0);
    accept(8'h12, 8'h34, 1'b1, 1'b1);
    wait_out("s4_lat", 4);
    result("s4", FI ? 8'h47 : 8'h46, 1'b0, !FI, FI ? 8'd2 : 8'd0, FI ? 2'd2 : 2'd0);

    // reset two cycles after acceptance aborts the operation
    accept(8'h5A, 8'h5A, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rdy", b8.in_ready, 1);
    check("s5_vld", b8.out_valid, 0);
    check("s5_err", b8.err_cnt, 0);
    check("s5_errc2", bc.err_cnt, 0);
    seen = 0;
    repeat (8) begin
      tick();
      if (b8.out_valid) seen++;
    end
    check("s5_no_out", seen, 0);

    // four injected mismatches: CNT_W=2 twin saturates at 3
    for (int i = 0; i < 4; i++) begin
      accept(8'h12, 8'h34, i[0], 1'b1);
      wait_out("s6_lat", 4);
      es  = (FI && i[0]) ? 8'h47 : 8'h46;
      ecc = FI ? ((i + 1 > 3) ? 2'd3 : 2'(i + 1)) : 2'd0;
      result("s6", es, 1'b0, !FI, FI ? 8'(i + 1) : 8'd0, ecc);
    end

    // WIDTH=2: single chunk, one-cycle latency, both paths
    for (int s = 0; s < 2; s++) begin
      check("w2_rdy", b2.in_ready, 1);
      b2.in0 = 2'b11; b2.in1 = 2'b11; b2.sel = s[0]; b2.in_valid = 1'b1;
      tick();
      b2.in_valid = 1'b0;
      c = 0;
      while (!b2.out_valid && c < 20) begin
        tick();
        c++;
      end
      check("w2_lat", c, 1);
      check("w2_sum", b2.sum, 2'b10);
      check("w2_carry", b2.carry, 1);
      check("w2_ok", b2.ok, 1);
      b2.out_ready = 1'b1;
      tick();
      b2.out_ready = 1'b0;
      check("w2_done", b2.out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/checked_add_seq.md
CHECKED_ADD_SEQ -- requirements
Module: checked_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are even, 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the mismatch counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have ports in0 and in1, input, WIDTH bits each: unsigned operands.
REQ-008 The block SHALL have port sel, input, 1 bit: result source; 0 selects the arithmetic path, 1 selects the LUT path.
REQ-009 The block SHALL have port inj, input, 1 bit: fault-injection request; ignored unless REQ-024 applies.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the selected sum.
REQ-013 The block SHALL have port carry, output, 1 bit: the selected carry-out (overflow) of the unsigned add.
REQ-014 The block SHALL have port ok, output, 1 bit: 1 when the arithmetic and LUT paths agree on {carry,sum}.
REQ-015 The block SHALL have port err_cnt, output, CNT_W bits: saturating count of mismatching results.

Function
REQ-016 The block SHALL implement a three-state FSM:
- IDLE: in_ready=1; on in_valid&&in_ready, latch in0, in1, sel and inj, and go to RUN.
- RUN: process one 2-bit chunk per cycle for N=WIDTH/2 cycles, then go to DONE.
- DONE: out_valid=1; on out_ready go to IDLE.
REQ-017 The arithmetic path SHALL compute {carry,sum}=in0+in1 at WIDTH+1 bits, registered at acceptance.
REQ-018 The LUT path SHALL use an internal 32-entry ROM addressed by {a_chunk[1:0], b_chunk[1:0], cin} and returning {cout, s[1:0]}.
- Chunks are processed from chunk 0 (LSBs) upward.
- cin=0 for chunk 0; otherwise cin is the previous chunk's cout.
- The final cout is the LUT carry.
REQ-019 Latency SHALL be as follows: acceptance at edge k gives out_valid high from edge k+N onward.
REQ-020 The selected outputs SHALL be:
- sum and carry come from the latched sel (arithmetic path if 0, LUT path if 1).
- ok and sum/carry are valid only while out_valid=1 and are held stable until the handshake completes.
- in_valid is ignored outside IDLE.
REQ-021 err_cnt SHALL increment by 1 on the RUN->DONE transition when ok=0, and SHALL saturate at 2^CNT_W-1.
REQ-022 Simultaneous out_ready in DONE and in_valid SHALL NOT accept new operands that cycle; acceptance happens next cycle, in IDLE.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL:
- go to state IDLE, so in_ready=1;
- set out_valid=0, sum=0, carry=0, ok=0, err_cnt=0, chunk index=0;
- clear all latched operands.
Reset during RUN or DONE SHALL discard the operation with no output and no err_cnt change.

Configuration
REQ-024 When CHECKED_ADD_FAULT_INJ_EN is defined, a latched inj=1 SHALL invert bit 0 of the LUT sum for chunk 0, without affecting the chunk 0 cout. When the macro is undefined, inj SHALL be ignored and the port SHALL still exist, keeping the interface identical.

Verification
REQ-025 The bench SHALL cover these directed scenarios (WIDTH=8 unless stated):
- in0=8'hFF, in1=8'h01, sel=0 -> out_valid after 4 cycles; sum=8'h00, carry=1, ok=1, err_cnt=0.
- in0=8'hA5, in1=8'h3C, sel=1, out_ready held low 3 cycles -> sum=8'hE1, carry=0, ok=1; out_valid and sum stable until out_ready; in_ready=0 throughout.
- With the macro defined: inj=1, in0=8'h12, in1=8'h34, sel=0 -> sum=8'h46, ok=0, err_cnt=1; same with sel=1 -> sum=8'h47, ok=0, err_cnt=2.
- rst=1 for one cycle two cycles after acceptance -> next cycle in_ready=1, out_valid=0, err_cnt=0; no result is ever emitted.
- CNT_W=2, four injected mismatches -> err_cnt saturates at 3.
- WIDTH=2: in0=2'b11, in1=2'b11 -> sum=2'b10, carry=1, ok=1, out_valid after 1 cycle.
